// File: rtl/aes_gcm_ghash_engine.sv
// aes_gcm_ghash_engine
// Multi-context GHASH/tag engine. Accepts AAD / CT / FINAL / START commands on a
// valid/ready handshake, folds each padded block into a per-context accumulator
// with a digit-serial GF(2^128) multiplier (DIGIT_BITS bits of X per cycle),
// tracks AAD/CT bit lengths, and on FINAL emits a truncated tag.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_valid / o_ready   command handshake (accept when both high)
//   i_ctx               target context
//   i_type              00 AAD, 01 CT, 10 FINAL, 11 START
//   i_data / i_nbytes   block (bit 127 = GCM bit 0) and valid leading bytes (0 = 16)
//   i_h, i_encrypted_j0 hash subkey and E(K,J0), captured on START
//   o_tag_valid/_ctx    one-cycle tag pulse and its context
//   o_tag               truncated tag, held until the next tag
//   o_err               one-cycle protocol-error pulse
module aes_gcm_ghash_engine #(
  parameter int unsigned NUM_CTX    = 2,
  parameter int unsigned DIGIT_BITS = 8,
  parameter int unsigned TAG_BYTES  = 16,
  localparam int unsigned CTX_W     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [CTX_W-1:0] i_ctx,
  input  logic [1:0]       i_type,
  input  logic [127:0]     i_data,
  input  logic [3:0]       i_nbytes,
  input  logic [127:0]     i_h,
  input  logic [127:0]     i_encrypted_j0,
  output logic             o_tag_valid,
  output logic [CTX_W-1:0] o_tag_ctx,
  output logic [127:0]     o_tag,
  output logic             o_err
);

  localparam int unsigned MUL_CYCLES = 128 / DIGIT_BITS;
  localparam int unsigned CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int unsigned CTXC_W     = CTX_W + 1;
  localparam logic [127:0] R_POLY    = {8'hE1, 120'h0};

  localparam logic [1:0] TY_AAD   = 2'b00;
  localparam logic [1:0] TY_CT    = 2'b01;
  localparam logic [1:0] TY_FINAL = 2'b10;
  localparam logic [1:0] TY_START = 2'b11;

  typedef enum logic [0:0] {ST_IDLE, ST_MUL} state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_AAD, PH_CT, PH_DONE} phase_e;

  // Keep the first n bytes (byte 0 = bits 127:120), zero the rest.
  function automatic logic [127:0] byte_mask(input logic [4:0] n);
    logic [127:0] m;
    m = '0;
    for (int unsigned b = 0; b < 16; b++) begin
      if (5'(b) < n) m[127 - 8*b -: 8] = 8'hFF;
    end
    return m;
  endfunction

  localparam logic [127:0] TAG_MASK = byte_mask(5'(TAG_BYTES));

  // Per-context state
  logic [127:0] h_q     [NUM_CTX];
  logic [127:0] ej0_q   [NUM_CTX];
  logic [127:0] acc_q   [NUM_CTX];
  logic [63:0]  aad_q   [NUM_CTX];
  logic [63:0]  ct_q    [NUM_CTX];
  phase_e       phase_q [NUM_CTX];
  logic         closed_q[NUM_CTX];

  // Engine state
  state_e           state_q, state_d;
  logic [127:0]     x_q, z_q, v_q;
  logic [127:0]     z_n, v_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CTX_W-1:0] mul_ctx_q;
  logic             mul_final_q;
  logic             ready_q, err_q, tag_valid_q;
  logic [127:0]     tag_q;
  logic [CTX_W-1:0] tag_ctx_q;

  // Command decode
  logic             ctx_ok, fire, legal, start_mul, err_d, partial, mul_last;
  logic [CTX_W-1:0] sel;
  logic [4:0]       nbytes;
  logic [63:0]      add_bits;
  logic [127:0]     operand, x_d;

  // Legality check and multiplier operand for the presented command.
  always_comb begin : decode
    ctx_ok   = CTXC_W'(i_ctx) < CTXC_W'(NUM_CTX);
    sel      = ctx_ok ? i_ctx : '0;
    nbytes   = (i_nbytes == 4'd0) ? 5'd16 : {1'b0, i_nbytes};
    partial  = (nbytes != 5'd16);
    add_bits = 64'(nbytes) << 3;
    fire     = i_valid & ready_q;
    legal    = 1'b0;
    case (i_type)
      TY_START: legal = 1'b1;
      TY_AAD:   legal = (phase_q[sel] == PH_AAD) && !closed_q[sel];
      TY_CT:    legal = (phase_q[sel] == PH_AAD) ||
                        ((phase_q[sel] == PH_CT) && !closed_q[sel]);
      default:  legal = (phase_q[sel] == PH_AAD) || (phase_q[sel] == PH_CT);
    endcase
    legal     = legal & ctx_ok;
    operand   = (i_type == TY_FINAL) ? {aad_q[sel], ct_q[sel]}
                                     : (i_data & byte_mask(nbytes));
    x_d       = acc_q[sel] ^ operand;
    start_mul = fire & legal & (i_type != TY_START);
    err_d     = fire & ~legal;
  end

  // Next-state logic of the engine FSM.
  always_comb begin : fsm_next
    state_d  = state_q;
    mul_last = 1'b0;
    case (state_q)
      ST_IDLE: if (start_mul) state_d = ST_MUL;
      ST_MUL: begin
        mul_last = (cnt_q == CNT_W'(MUL_CYCLES - 1));
        if (mul_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One digit of the shift-and-add multiply: consume DIGIT_BITS MSBs of X.
  always_comb begin : digit_step
    z_n = z_q;
    v_n = v_q;
    for (int unsigned i = 0; i < DIGIT_BITS; i++) begin
      if (x_q[127 - i]) z_n = z_n ^ v_n;
      v_n = v_n[0] ? ((v_n >> 1) ^ R_POLY) : (v_n >> 1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin : fsm_reg
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Context bookkeeping, multiplier datapath and registered outputs.
  always_ff @(posedge clk) begin : datapath
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
        h_q[c]      <= '0;
        ej0_q[c]    <= '0;
        acc_q[c]    <= '0;
        aad_q[c]    <= '0;
        ct_q[c]     <= '0;
        phase_q[c]  <= PH_IDLE;
        closed_q[c] <= 1'b0;
      end
      x_q         <= '0;
      z_q         <= '0;
      v_q         <= '0;
      cnt_q       <= '0;
      mul_ctx_q   <= '0;
      mul_final_q <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_q       <= '0;
      tag_ctx_q   <= '0;
    end else begin
      if (fire && legal) begin
        case (i_type)
          TY_START: begin
            h_q[sel]      <= i_h;
            ej0_q[sel]    <= i_encrypted_j0;
            acc_q[sel]    <= '0;
            aad_q[sel]    <= '0;
            ct_q[sel]     <= '0;
            closed_q[sel] <= 1'b0;
            phase_q[sel]  <= PH_AAD;
          end
          TY_AAD: begin
            aad_q[sel]    <= aad_q[sel] + add_bits;
            closed_q[sel] <= partial;
          end
          TY_CT: begin
            // First CT leaves the AAD phase; its closed flag starts afresh.
            ct_q[sel]     <= ct_q[sel] + add_bits;
            closed_q[sel] <= partial;
            phase_q[sel]  <= PH_CT;
          end
          default: ;
        endcase
      end
      if (start_mul) begin
        x_q         <= x_d;
        z_q         <= '0;
        v_q         <= h_q[sel];
        cnt_q       <= '0;
        mul_ctx_q   <= sel;
        mul_final_q <= (i_type == TY_FINAL);
      end
      if (state_q == ST_MUL) begin
        x_q   <= x_q << DIGIT_BITS;
        z_q   <= z_n;
        v_q   <= v_n;
        cnt_q <= cnt_q + CNT_W'(1);
        if (mul_last) begin
          acc_q[mul_ctx_q] <= z_n;
          if (mul_final_q) begin
            tag_q              <= (z_n ^ ej0_q[mul_ctx_q]) & TAG_MASK;
            tag_ctx_q          <= mul_ctx_q;
            phase_q[mul_ctx_q] <= PH_DONE;
          end
        end
      end
      tag_valid_q <= mul_last & mul_final_q;
      err_q       <= err_d;
      ready_q     <= (state_d == ST_IDLE);
    end
  end

  assign o_ready     = ready_q;
  assign o_err       = err_q;
  assign o_tag_valid = tag_valid_q;
  assign o_tag       = tag_q;
  assign o_tag_ctx   = tag_ctx_q;

endmodule

// File: tb/tb_aes_gcm_ghash_engine.sv
// Testbench for aes_gcm_ghash_engine: randomized and directed commands, a
// polynomial-arithmetic GHASH reference model, and a scoreboard queue popped by
// an output monitor on every o_err / o_tag_valid pulse.
module tb_aes_gcm_ghash_engine;

  localparam int unsigned NCTX = 3;
  localparam int unsigned DIG  = 8;
  localparam int unsigned TAGB = 16;
  localparam int unsigned MULC = 128 / DIG;
  localparam int unsigned CW   = 2;

  localparam logic [1:0] T_AAD = 2'b00, T_CT = 2'b01, T_FIN = 2'b10, T_START = 2'b11;

  localparam logic [127:0] NIST_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] NIST_EJ0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] NIST_C2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] NIST_T2  = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic          clk, rst_n, i_valid, o_ready, o_tag_valid, o_err;
  logic [CW-1:0] i_ctx, o_tag_ctx;
  logic [1:0]    i_type;
  logic [127:0]  i_data, i_h, i_encrypted_j0, o_tag;
  logic [3:0]    i_nbytes;

  aes_gcm_ghash_engine #(.NUM_CTX(NCTX), .DIGIT_BITS(DIG), .TAG_BYTES(TAGB)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_ctx(i_ctx), .i_type(i_type), .i_data(i_data), .i_nbytes(i_nbytes),
    .i_h(i_h), .i_encrypted_j0(i_encrypted_j0),
    .o_tag_valid(o_tag_valid), .o_tag_ctx(o_tag_ctx), .o_tag(o_tag), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_err;
    logic [CW-1:0] ctx;
    logic [127:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic [127:0] m_h[NCTX], m_ej0[NCTX], m_acc[NCTX];
  logic [63:0]  m_aad[NCTX], m_ct[NCTX];
  int           m_ph[NCTX];   // 0 idle, 1 aad, 2 ct, 3 done
  bit           m_cl[NCTX];
  bit           use_ovr = 0;
  logic [127:0] ovr_tag;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] rev128(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127 - i];
    return r;
  endfunction

  // GF(2^128) product as polynomials: carry-less multiply, then reduce by
  // x^128 = x^7 + x^2 + x + 1. GCM bit 0 (vector bit 127) is the x^0 term.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [255:0] p;
    logic [127:0] a, b;
    a = rev128(x);
    b = rev128(y);
    p = '0;
    for (int i = 0; i < 128; i++) if (a[i]) p = p ^ (256'(b) << i);
    for (int i = 254; i >= 128; i--) begin
      if (p[i]) begin
        p[i] = 1'b0;
        p[i - 128 +: 8] = p[i - 128 +: 8] ^ 8'h87;
      end
    end
    return rev128(p[127:0]);
  endfunction

  function automatic logic [127:0] keep_bytes(input int n);
    logic [127:0] m;
    m = '0;
    for (int b = 0; b < n; b++) m[127 - 8*b -: 8] = 8'hFF;
    return m;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCTX; c++) begin
      m_h[c] = '0; m_ej0[c] = '0; m_acc[c] = '0;
      m_aad[c] = '0; m_ct[c] = '0; m_ph[c] = 0; m_cl[c] = 0;
    end
    exp_q.delete();
  endtask

  // Apply one accepted command to the model; queue any expected output event.
  task automatic model_cmd(input int c, input logic [1:0] t, input logic [127:0] d,
                           input logic [3:0] nb, input logic [127:0] h,
                           input logic [127:0] ej0, output bit mul);
    int n;
    bit ok;
    exp_t e;
    logic [127:0] s;
    n = (nb == 4'd0) ? 16 : int'(nb);
    mul = 0;
    ok = 0;
    if (c < NCTX) begin
      case (t)
        T_START: ok = 1;
        T_AAD:   ok = (m_ph[c] == 1) && !m_cl[c];
        T_CT:    ok = (m_ph[c] == 1) || ((m_ph[c] == 2) && !m_cl[c]);
        default: ok = (m_ph[c] == 1) || (m_ph[c] == 2);
      endcase
    end
    e.ctx = CW'(c);
    e.tag = '0;
    if (!ok) begin
      e.is_err = 1'b1;
      exp_q.push_back(e);
      return;
    end
    case (t)
      T_START: begin
        m_h[c] = h; m_ej0[c] = ej0; m_acc[c] = '0;
        m_aad[c] = '0; m_ct[c] = '0; m_ph[c] = 1; m_cl[c] = 0;
      end
      T_AAD: begin
        m_acc[c] = gf_mul(m_acc[c] ^ (d & keep_bytes(n)), m_h[c]);
        m_aad[c] = m_aad[c] + 64'(8 * n);
        m_cl[c] = (n < 16);
        mul = 1;
      end
      T_CT: begin
        m_acc[c] = gf_mul(m_acc[c] ^ (d & keep_bytes(n)), m_h[c]);
        m_ct[c] = m_ct[c] + 64'(8 * n);
        m_ph[c] = 2;
        m_cl[c] = (n < 16);
        mul = 1;
      end
      default: begin
        s = gf_mul(m_acc[c] ^ {m_aad[c], m_ct[c]}, m_h[c]);
        m_acc[c] = s;
        m_ph[c] = 3;
        mul = 1;
        e.is_err = 1'b0;
        e.tag = (s ^ m_ej0[c]) & keep_bytes(TAGB);
        if (use_ovr) begin
          e.tag = ovr_tag;
          use_ovr = 0;
        end
        exp_q.push_back(e);
      end
    endcase
  endtask

  // Drive one command; optionally check how long o_ready stays low afterwards.
  task automatic send(input int c, input logic [1:0] t, input logic [127:0] d,
                      input logic [3:0] nb, input logic [127:0] h,
                      input logic [127:0] ej0, input bit wait_done);
    bit mul;
    int g, low;
    g = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (o_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: o_ready=%b required 1", o_ready);
      return;
    end
    i_ctx = CW'(c); i_type = t; i_data = d; i_nbytes = nb;
    i_h = h; i_encrypted_j0 = ej0; i_valid = 1'b1;
    model_cmd(c, t, d, nb, h, ej0, mul);
    @(negedge clk);
    i_valid = 1'b0;
    i_data = {$urandom, $urandom, $urandom, $urandom};
    if (!wait_done) return;
    if (mul) begin
      low = 0;
      while (o_ready !== 1'b1 && low < 300) begin
        low++;
        @(negedge clk);
      end
      check("ready_low_cycles", 128'(low), 128'(MULC));
    end else begin
      check("ready_stays_high", 128'(o_ready), 128'(1));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 128'(o_ready), 128'(0));
    check({tag, "_tag_valid"}, 128'(o_tag_valid), 128'(0));
    check({tag, "_err"}, 128'(o_err), 128'(0));
    check({tag, "_tag"}, o_tag, 128'(0));
    check({tag, "_tag_ctx"}, 128'(o_tag_ctx), 128'(0));
  endtask

  // Monitor: every output event must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (o_err === 1'b1 || o_tag_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: err=%b tag_valid=%b ctx=%0d tag=%h",
                 o_err, o_tag_valid, o_tag_ctx, o_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_err", 128'(o_err), 128'(mon_e.is_err));
        check("evt_tag_valid", 128'(o_tag_valid), 128'(!mon_e.is_err));
        if (!mon_e.is_err) begin
          check("tag_ctx", 128'(o_tag_ctx), 128'(mon_e.ctx));
          check("tag_value", o_tag, mon_e.tag);
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  logic [127:0] garbage;
  int           g;

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_ctx = '0; i_type = '0; i_data = '0;
    i_nbytes = '0; i_h = '0; i_encrypted_j0 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'(o_ready), 128'(1));

    // NIST case 1 on ctx0
    send(0, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);
    ovr_tag = NIST_EJ0; use_ovr = 1;
    send(0, T_FIN, '0, 4'd0, '0, '0, 1);
    repeat (3) @(negedge clk);
    check("tag_held", o_tag, NIST_EJ0);

    // NIST case 2 on ctx0
    send(0, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);
    send(0, T_CT, NIST_C2, 4'd0, '0, '0, 1);
    ovr_tag = NIST_T2; use_ovr = 1;
    send(0, T_FIN, '0, 4'd0, '0, '0, 1);

    // Interleaved: case 1 on ctx1, case 2 on ctx0
    send(1, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);
    send(0, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);
    send(0, T_CT, NIST_C2, 4'd0, '0, '0, 1);
    ovr_tag = NIST_EJ0; use_ovr = 1;
    send(1, T_FIN, '0, 4'd0, '0, '0, 1);
    ovr_tag = NIST_T2; use_ovr = 1;
    send(0, T_FIN, '0, 4'd0, '0, '0, 1);

    // Partial block with garbage tail, then a second CT that must be rejected
    garbage = {32'hdeadbeef, $urandom, $urandom, $urandom} | 128'h1;
    send(0, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);
    send(0, T_CT, garbage, 4'd4, '0, '0, 1);
    send(0, T_CT, NIST_C2, 4'd0, '0, '0, 1);
    send(0, T_FIN, '0, 4'd0, '0, '0, 1);
    send(1, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);
    send(1, T_CT, garbage & {32'hffffffff, 96'h0}, 4'd4, '0, '0, 1);
    send(1, T_FIN, '0, 4'd0, '0, '0, 1);

    // Protocol errors
    send(0, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);
    send(0, T_CT, NIST_C2, 4'd0, '0, '0, 1);
    send(0, T_AAD, NIST_C2, 4'd0, '0, '0, 1);         // AAD after CT
    send(0, T_FIN, '0, 4'd0, '0, '0, 1);
    send(0, T_CT, NIST_C2, 4'd0, '0, '0, 1);          // data to DONE
    send(0, T_FIN, '0, 4'd0, '0, '0, 1);              // FINAL to DONE
    send(3, T_AAD, NIST_C2, 4'd0, '0, '0, 1);         // ctx out of range
    send(3, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);
    send(2, T_AAD, NIST_C2, 4'd0, '0, '0, 1);         // never-started context
    send(0, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);  // restart clears DONE
    send(0, T_AAD, NIST_C2, 4'd0, '0, '0, 1);
    send(0, T_CT, NIST_C2, 4'd7, '0, '0, 1);
    send(0, T_FIN, '0, 4'd0, '0, '0, 1);

    // Randomized traffic across all contexts
    for (int c = 0; c < NCTX; c++)
      send(c, T_START, '0, 4'd0, {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 1);
    for (int k = 0; k < 60; k++) begin
      int rc, rt;
      logic [1:0] ty;
      logic [3:0] nb;
      rc = ($urandom_range(0, 11) == 0) ? 3 : int'($urandom_range(0, 2));
      rt = int'($urandom_range(0, 19));
      ty = (rt < 3) ? T_START : (rt < 9) ? T_AAD : (rt < 16) ? T_CT : T_FIN;
      nb = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      send(rc, ty, {$urandom, $urandom, $urandom, $urandom}, nb,
           {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 1);
    end

    // Reset in the third cycle of a multiply
    send(0, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);
    send(0, T_CT, NIST_C2, 4'd0, '0, '0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs_zero("midmul_reset");
    repeat (MULC) @(negedge clk);
    check("midmul_no_tag", 128'(o_tag_valid), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midmul_reset", 128'(o_ready), 128'(1));
    send(0, T_START, '0, 4'd0, NIST_H, NIST_EJ0, 1);
    send(0, T_CT, NIST_C2, 4'd0, '0, '0, 1);
    ovr_tag = NIST_T2; use_ovr = 1;
    send(0, T_FIN, '0, 4'd0, '0, '0, 1);

    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_gcm_ghash_engine.md
Name: aes_gcm_ghash_engine

Overview:
Multi-context GHASH/tag engine for the AES-GCM pipeline, downstream of the CTR encryption stages. Accepts AAD and ciphertext blocks over a valid/ready handshake and multiplies each into a per-context accumulator using a digit-serial GF(2^128) multiplier. It pads partial final blocks, counts AAD and ciphertext lengths internally, and emits a truncated tag.

Parameters:
NUM_CTX, 2, number of independent GCM contexts (1..16); CTX_W = max(1, clog2(NUM_CTX))
DIGIT_BITS, 8, multiplier digit width; legal values 1,2,4,8,16,32,64,128; MUL_CYCLES = 128/DIGIT_BITS
TAG_BYTES, 16, tag length in bytes (4..16)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_valid  in  1  block/command valid
o_ready  out  1  engine can accept a command this cycle
i_ctx  in  CTX_W  target context
i_type  in  2  00 AAD, 01 CT, 10 FINAL, 11 START
i_data  in  128  block, bit 0 = MSB (GCM bit order)
i_nbytes  in  4  valid leading bytes of i_data; 0 means 16
i_h  in  128  hash subkey H (sampled on START only)
i_encrypted_j0  in  128  E(K,J0) (sampled on START only)
o_tag_valid  out  1  one-cycle tag pulse, no backpressure
o_tag_ctx  out  CTX_W  context of o_tag
o_tag  out  128  tag; bytes at index TAG_BYTES and above are forced to 0
o_err  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset: synchronous and active-low; sampled at the clk edge. While rst_n=0: o_ready=0, o_tag_valid=0, o_err=0, o_tag=0, o_tag_ctx=0. All contexts go to IDLE with accumulator, lengths, H and EJ0 at 0.
- Reset mid-multiply aborts the operation. No tag or error is emitted. o_ready=1 in the first cycle after rst_n returns to 1.
- Per-context state: H, EJ0, acc[128], aad_bits[64], ct_bits[64], phase (IDLE, AAD, CT, DONE), and a closed flag for the current phase.
- Engine FSM has two states, ST_IDLE (o_ready=1) and ST_MUL (o_ready=0). A command is accepted on a clk edge where i_valid & o_ready.
- START: loads i_h and i_encrypted_j0, clears acc, lengths and closed flag, and sets phase=AAD. Legal in any phase; it restarts the context. No multiply; FSM stays in ST_IDLE.
- AAD: legal in phase AAD when not closed. CT: legal in phase AAD or CT when not closed in CT; the first CT moves phase to CT.
- Data block processing: n = (i_nbytes==0) ? 16 : i_nbytes. Bytes n..15 of i_data are zeroed. The matching length counter increases by 8*n, wrapping mod 2^64. If n<16, the phase is closed and any later block of the same type is an error.
- FINAL: legal in phase AAD or CT. Operand is {aad_bits, ct_bits}; i_data is ignored.
- Multiply: X = acc ^ operand, computed at accept; the product X*H is computed digit-serially over MUL_CYCLES cycles.
- Cycle timing for an accept at edge k:
  - o_ready=0 in cycles k+1 .. k+MUL_CYCLES.
  - acc is written at edge k+MUL_CYCLES.
  - o_ready returns to 1 in the following cycle.
- FINAL completion: at edge k+MUL_CYCLES the engine also registers o_tag = truncate(product ^ EJ0), o_tag_ctx, and o_tag_valid=1 for one cycle; the context goes to DONE. o_tag holds its value until the next tag.
- MUL_CYCLES=1 case: one multiply completes per 2 cycles.
- Illegal command: an illegal type/phase, a DONE or IDLE context (except START), or i_ctx >= NUM_CTX. The command is consumed with no state change; o_err pulses in cycle k+1 and o_ready stays 1.
- i_nbytes is ignored for FINAL and START.
- Contexts are independent: commands to different contexts interleave freely, one multiply in flight at a time.

Test Plan:
- Reset, START ctx0 with H=66e94bd4ef8a2c3b884cfa59ca342b2e, EJ0=58e2fccefa7e3061367f1d57a4e7455a, then FINAL -> one o_tag_valid pulse with o_tag=58e2fccefa7e3061367f1d57a4e7455a and o_tag_ctx=0 (NIST GCM case 1).
- Same START, CT 0388dace60b6a392f328c2b971b2fe78 (nbytes=0), FINAL -> o_tag=ab6e47d42cec13bdf53a67b21257bddf (NIST GCM case 2). Check o_ready is low for exactly MUL_CYCLES cycles after each accept.
- Interleave case 1 on ctx1 and case 2 on ctx0 with commands alternating -> both tags correct and tagged with the right o_tag_ctx. Repeat for DIGIT_BITS=1, 8 and 128.
- Partial block: CT with nbytes=4 whose bytes 4..15 are garbage must give the same tag as CT with those bytes zero; lengths contribute ct_bits=32. A second CT after it -> o_err pulse, and the later tag is unchanged.
- Protocol errors: AAD after CT, any data to a DONE context, and i_ctx=NUM_CTX -> o_err pulse, no state change. A subsequent START clears the error condition.
- Assert rst_n=0 at cycle 3 of a multiply with DIGIT_BITS=8 -> no o_tag_valid and all outputs 0. After release, a fresh case-2 sequence yields the correct tag.
